// File: rtl/add_drv_chk_pkg.sv
// Shared types and constants for the adder operand driver / result checker.
package add_chk_pkg;

    localparam int ADD_W     = 4;
    localparam int ADD_SUM_W = ADD_W + 1;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [7:0]           idx;
        logic [ADD_SUM_W-1:0] sum;
    } exp_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/add_drv_chk_if.sv
// Operand/sum bus between the checker (master) and the registered adder (slave).
interface add_drv_chk_if #(
    parameter int W     = 4,
    parameter int SUM_W = W + 1
);
    logic [W-1:0]     a_o;
    logic [W-1:0]     b_o;
    logic [SUM_W-1:0] sum_i;

    modport master (output a_o, output b_o, input  sum_i);
    modport slave  (input  a_o, input  b_o, output sum_i);
endinterface

// File: rtl/add_drv_chk_exp_pipe.sv
// LAT-deep shift register of expected results, synchronously cleared on reset or run start.
module add_exp_pipe
    import add_chk_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  exp_t push_i,
    output exp_t pop_o
);
    exp_t stage_q [LAT];

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            for (int unsigned i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= push_i;
            for (int unsigned i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign pop_o = stage_q[LAT-1];

endmodule

// File: rtl/add_drv_chk.sv
// Drives NUM_VEC operand pairs into a registered adder and checks each sum LAT cycles later.
// Define ADD_DRV_CHK_LFSR_EN to source operands from an 8-bit LFSR instead of the index pattern.
module add_drv_chk
    import add_chk_pkg::*;
#(
    parameter int W       = ADD_W,
    parameter int SUM_W   = ADD_SUM_W,
    parameter int NUM_VEC = 16,
    parameter int LAT     = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    add_drv_chk_if.master    add,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       first_err_idx
);
    state_t           state_q;
    logic [7:0]       idx_q;
    logic [7:0]       nidx;
    logic [2:0]       drain_q;
    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     va, vb;
    logic             busy_q, done_q, pass_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       first_err_q, first_err_d;
    logic             run_start;
    exp_t             push, pop;

    assign run_start = ((state_q == IDLE) || (state_q == DONE)) && start;
    // Index of the vector to present next: 0 on run start, idx+1 while driving.
    assign nidx = (state_q == DRIVE) ? idx_q + 8'd1 : '0;

`ifdef ADD_DRV_CHK_LFSR_EN
    logic [7:0] lfsr_q, lfsr_n;

    assign lfsr_n = (state_q == DRIVE) ? lfsr_step(lfsr_q) : LFSR_SEED;
    assign va     = lfsr_n[W-1:0];
    assign vb     = lfsr_n[7:8-W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (run_start || (state_q == DRIVE)) begin
            lfsr_q <= lfsr_n;
        end
    end
`else
    assign va = nidx[W-1:0];
    assign vb = W'(nidx + 8'd3);
`endif

    add_exp_pipe #(.LAT(LAT)) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (run_start),
        .push_i (push),
        .pop_o  (pop)
    );

    always_comb begin
        push        = '0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (state_q == DRIVE) begin
            push.valid = 1'b1;
            push.idx   = idx_q;
            push.sum   = ADD_SUM_W'(SUM_W'(a_q) + SUM_W'(b_q));
        end
        if (pop.valid && (ADD_SUM_W'(add.sum_i) != pop.sum)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (first_err_q == 8'hFF) first_err_d = pop.idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drain_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= 8'hFF;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= DRIVE;
                        idx_q       <= '0;
                        a_q         <= va;
                        b_q         <= vb;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        first_err_q <= 8'hFF;
                    end
                end
                DRIVE: begin
                    if (idx_q == 8'(NUM_VEC - 1)) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                    end else begin
                        idx_q <= nidx;
                        a_q   <= va;
                        b_q   <= vb;
                    end
                end
                DRAIN: begin
                    if (drain_q == 3'(LAT - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
            endcase
        end
    end

    assign add.a_o       = a_q;
    assign add.b_o       = b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_add_drv_chk.sv
// Bench for add_drv_chk: a configurable adder stub plus an operand/result reference model.
module tb_add_drv_chk;

    localparam int W       = 4;
    localparam int SUM_W   = 5;
    localparam int NUM_VEC = 16;
    localparam int LAT     = 1;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       first_err_idx;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Stub behaviour: 0 correct, 1 bit0 flipped on vector flip_k, 2 two-cycle latency, 3 inverted sum.
    int unsigned mode   = 0;
    int unsigned flip_k = 0;

    int unsigned va [NUM_VEC];
    int unsigned vb [NUM_VEC];

    add_drv_chk_if #(.W(W), .SUM_W(SUM_W)) ifc ();

    add_drv_chk #(
        .W       (W),
        .SUM_W   (SUM_W),
        .NUM_VEC (NUM_VEC),
        .LAT     (LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .add           (ifc),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    logic [SUM_W-1:0] s1 = '0, s2 = '0;
    int unsigned      vk = 0;

    always @(posedge clk) begin
        logic [SUM_W-1:0] s;
        s = SUM_W'(ifc.a_o) + SUM_W'(ifc.b_o);
        if (mode == 1 && busy && vk == flip_k) s = s ^ SUM_W'(1);
        if (mode == 3) s = ~s;
        s1 <= s;
        s2 <= s1;
        vk <= busy ? vk + 1 : 0;
    end

    assign ifc.sum_i = (mode == 2) ? s2 : s1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned returned_sum(input int unsigned md, input int unsigned fk,
                                                 input int unsigned k);
        int unsigned s;
        s = va[k] + vb[k];
        case (md)
            1:       return (k == fk) ? (s ^ 1) : s;
            2:       return (k == 0) ? 0 : va[k-1] + vb[k-1];
            3:       return (~s) & ((1 << SUM_W) - 1);
            default: return s;
        endcase
    endfunction

    task automatic run_vec(input int unsigned md, input int unsigned fk, input bit hold,
                           input bit golden);
        int unsigned exp_err, exp_first, c;
        bit          seen, busy_drop;
        mode      = md;
        flip_k    = fk;
        exp_err   = 0;
        exp_first = 255;
        for (int k = 0; k < NUM_VEC; k++) begin
            if (returned_sum(md, fk, k) != va[k] + vb[k]) begin
                if (exp_err < (1 << CNT_W) - 1) exp_err++;
                if (exp_first == 255) exp_first = k;
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        c         = 0;
        seen      = 1'b0;
        busy_drop = 1'b0;
        while (c < 200 && !seen) begin
            if (c < NUM_VEC) begin
                chk($sformatf("op_a[%0d]", c), ifc.a_o, va[c]);
                chk($sformatf("op_b[%0d]", c), ifc.b_o, vb[c]);
            end
`ifndef ADD_DRV_CHK_LFSR_EN
            if (golden && c == 13) begin
                chk("vec13_a", ifc.a_o, 13);
                chk("vec13_b", ifc.b_o, 0);
            end
            if (golden && c == 14) begin
                chk("vec14_a", ifc.a_o, 14);
                chk("vec14_b", ifc.b_o, 1);
                chk("sum13", ifc.sum_i, 13);
            end
            if (golden && c == 15) chk("sum14", ifc.sum_i, 15);
`endif
            if (c == NUM_VEC + LAT - 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_drop = 1'b1;
                c++;
                @(negedge clk);
            end
        end
        chk("done_latency", c, NUM_VEC + LAT);
        chk("busy_through_run", busy_drop, 0);
        chk("busy_at_done", busy, 0);
        chk("err_cnt", err_cnt, exp_err);
        chk("first_err_idx", first_err_idx, exp_first);
        chk("pass", pass, (exp_err == 0) ? 1 : 0);
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1);
        chk("err_cnt_hold", err_cnt, exp_err);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_first_err"}, first_err_idx, 255);
        chk({tag, "_a"}, ifc.a_o, 0);
        chk({tag, "_b"}, ifc.b_o, 0);
    endtask

    initial begin
        logic [7:0] l;
        l = 8'hA5;
        for (int k = 0; k < NUM_VEC; k++) begin
`ifdef ADD_DRV_CHK_LFSR_EN
            va[k] = l[3:0];
            vb[k] = l[7:4];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
`else
            va[k] = k % 16;
            vb[k] = (k + 3) % 16;
`endif
        end

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_done", done, 0);

        run_vec(0, 0, 1'b0, 1'b1);
        run_vec(1, 5, 1'b0, 1'b0);
        run_vec(2, 0, 1'b0, 1'b0);
        run_vec(3, 0, 1'b0, 1'b0);
        run_vec(0, 0, 1'b1, 1'b0);

        // Abort mid-run with a failing stub so stale errors would be visible.
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("abort");
        rst_n = 1'b1;
        repeat (NUM_VEC + LAT + 2) @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_no_err", err_cnt, 0);

        run_vec(0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_vec($urandom_range(0, 3), $urandom_range(0, NUM_VEC - 1), 1'($urandom_range(0, 1)),
                    1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/add_drv_chk.md
Name: add_drv_chk

Overview:
- Self-checking operand driver and result checker for the registered 4-bit adder on the add interface. This block is the opposite end of that interface.
- It sources a, b and sinks the registered sum.
- It generates NUM_VEC operand pairs back-to-back and tracks the adder's pipeline latency with an expected-value delay line.
- It compares each returned sum, counts mismatches and reports pass/fail, so adder bring-up and regressions run without a behavioural testbench.

Parameters:
- W, 4: operand width.
- SUM_W, W+1: compared sum width. Sum bits above SUM_W are ignored.
- NUM_VEC, 16: number of operand pairs per run, 1..256.
- LAT, 1: adder latency in clocks, from operands presented to sum valid. Legal range 1..4.
- CNT_W, 4: width of the error counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: run request, sampled in IDLE and DONE only.
- a_o, out, W: operand a, registered.
- b_o, out, W: operand b, registered.
- sum_i, in, SUM_W: registered sum returned from the adder.
- busy, out, 1: high in DRIVE and DRAIN.
- done, out, 1: high in DONE.
- pass, out, 1: done and err_cnt==0.
- err_cnt, out, CNT_W: number of mismatches, saturating.
- first_err_idx, out, 8: vector index of the first mismatch. Holds 0xFF if there is none.

Behaviour:
- Reset, clk is the only clock and rst_n is a synchronous, active-low reset:
  - state=IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0xFF.
  - idx=0 and all delay-line valid bits are cleared.
- FSM state IDLE: start=1 moves to DRIVE at the next edge. That edge also clears err_cnt, first_err_idx and idx.
- FSM state DRIVE:
  - Vector k=idx is presented on a_o/b_o during cycle k.
  - The expected value is a_o+b_o, zero-extended to SUM_W. It is pushed into the delay line together with a valid bit and k.
  - idx increments each cycle.
  - After vector NUM_VEC-1 the FSM moves to DRAIN, and a_o/b_o return to 0.
- FSM state DRAIN: lasts exactly LAT cycles with no new pushes, then moves to DONE.
- FSM state DONE: done=1 and outputs hold. start=1 restarts exactly as from IDLE.
- Checking:
  - The delay line has LAT stages.
  - At the stage-LAT output, when the valid bit is set, sum_i is compared to the expected value.
  - On mismatch, err_cnt increments, saturating at 2^CNT_W-1.
  - If first_err_idx is 0xFF, it captures k.
  - Entries without the valid bit are never compared.
- Latency: a run takes NUM_VEC+LAT cycles from the first DRIVE cycle to done rising.
- Boundaries:
  - start while busy is ignored.
  - rst_n low mid-run aborts the run on that edge, clears the delay line, and no partial result is reported.
  - NUM_VEC=1 gives DRIVE for one cycle.
  - Operand overflow is never truncated, e.g. 15+15=30 is 5'b11110.

Optional Feature:
- Macro ADD_DRV_CHK_LFSR_EN.
- When defined, operands come from an 8-bit Fibonacci LFSR:
  - Taps are 8,6,5,4, the seed is 8'hA5, and the LFSR steps once per DRIVE cycle.
  - a_o=lfsr[W-1:0] and b_o=lfsr[7:8-W].
  - The LFSR is reseeded on every run start.
- When undefined, operands are deterministic: a_o=idx[W-1:0] and b_o=(idx+3) mod 2^W.
- Checking and timing are identical in both builds.

Decomposition:
- Package add_chk_pkg holds:
  - the enum state_t {IDLE, DRIVE, DRAIN, DONE};
  - the LFSR seed and taps constants;
  - the exp_t struct {valid, idx[7:0], sum[SUM_W-1:0]}.
- Sub-module add_exp_pipe is the LAT-deep shift register of exp_t, with a synchronous clear. The top instantiates it once.

Test Plan:
- Deterministic build, correct LAT=1 adder stub, start pulse: done after 17 cycles, err_cnt=0, pass=1, first_err_idx=0xFF. Vector 13 is a=13, b=0, sum 13, and vector 14 is a=14, b=1, sum 15.
- Stub forces sum_i bit0 flipped on vector 5 only: err_cnt=1, first_err_idx=5, pass=0.
- Stub with latency 2 while LAT=1: mismatches on most vectors, and first_err_idx=0 because sum_i is still 0 vs expected 3.
- Every sum inverted, CNT_W=4: err_cnt saturates at 15 and does not wrap.
- start held high through DRIVE: no restart and the run completes normally. rst_n low at cycle 8: all outputs return to reset values the next cycle.
- LFSR build: the first three operand pairs match the golden LFSR sequence from seed 0xA5, err_cnt=0, and a rerun reproduces the same pairs.
